// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// FSM states, opcodes, funct codes and ALU operation codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW,
      OP_BEQ, OP_ADDI, OP_J: return 1'b1;
      default:               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_control_alu_decoder.sv
// ALU decoder: maps ALUOp and Funct onto the 3-bit ALU operation.
// Unknown R-type functs fall back to add.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  output logic [2:0] ALUControl
);

  // Pick the ALU operation; reserved ALUOp 11 behaves as add
  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (Funct)
          F_ADD:   ALUControl = ALU_ADD;
          F_SUB:   ALUControl = ALU_SUB;
          F_AND:   ALUControl = ALU_AND;
          F_OR:    ALUControl = ALU_OR;
          F_SLT:   ALUControl = ALU_SLT;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control: Moore FSM with memory wait states,
// combinational datapath controls and ALU decode.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       IllegalOp
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state;
  state_t     st;
  logic [3:0] cnt;
  logic       done;
  logic [1:0] alu_op;
  logic       pc_write;
  logic       branch;
  logic       mem_write_r;
  logic       ir_write_r;
  logic       reg_write_r;
  logic       illegal_r;

  assign done = (cnt == WAIT_LAST);
  // Reset presents FETCH selects so the datapath sits idle
  assign st   = reset ? S_FETCH : state;

  // State sequencing and memory wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (done) begin
            state <= S_DECODE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_DECODE: begin
          case (Op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXECUTE;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADDI:      state <= S_ADDIEX;
            OP_J:         state <= S_JUMP;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          state <= (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          if (done) begin
            state <= S_MEMWB;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_MEMWRITE: begin
          if (done) begin
            state <= S_FETCH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_EXECUTE: state <= S_ALUWB;
        S_ADDIEX:  state <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_ADDIWB,
        S_BRANCH, S_JUMP: state <= S_FETCH;
        default: begin
          state <= S_FETCH;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Per-state datapath controls
  always_comb begin
    IorD        = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 2'b00;
    alu_op      = ALUOP_ADD;
    pc_write    = 1'b0;
    branch      = 1'b0;
    mem_write_r = 1'b0;
    ir_write_r  = 1'b0;
    reg_write_r = 1'b0;
    illegal_r   = 1'b0;
    case (st)
      S_FETCH: begin
        ALUSrcB    = 2'b01;
        ir_write_r = done;
        pc_write   = done;
      end
      S_DECODE: begin
        ALUSrcB   = 2'b11;
        illegal_r = ~op_supported(Op);
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMREAD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg    = 1'b1;
        reg_write_r = 1'b1;
      end
      S_MEMWRITE: begin
        IorD        = 1'b1;
        mem_write_r = done;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst      = 1'b1;
        reg_write_r = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_SUB;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: reg_write_r = 1'b1;
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign MemWrite  = mem_write_r & ~reset;
  assign IRWrite   = ir_write_r & ~reset;
  assign RegWrite  = reg_write_r & ~reset;
  assign IllegalOp = illegal_r & ~reset;
  assign PCEn      = (pc_write | (branch & Zero)) & ~reset;

  alu_decoder u_alu_dec (
    .ALUOp      (alu_op),
    .Funct      (Funct),
    .ALUControl (ALUControl)
  );

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for the multicycle MIPS control unit: per-cycle expected
// control vectors queued per instruction, checked on negedge.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal;
  } out_t;

  typedef struct {
    out_t  e;
    string nm;
  } sb_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alu;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;

  logic       iord    [2];
  logic       mem_wr  [2];
  logic       ir_wr   [2];
  logic       reg_dst [2];
  logic       m2r     [2];
  logic       reg_wr  [2];
  logic       src_a   [2];
  logic [1:0] src_b   [2];
  logic [2:0] alu     [2];
  logic [1:0] pc_src  [2];
  logic       pc_en   [2];
  logic       illegal [2];
  out_t       act     [2];

  sb_t  q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tv[14];

  mips_multicycle_control #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(iord[0]), .MemWrite(mem_wr[0]), .IRWrite(ir_wr[0]),
    .RegDst(reg_dst[0]), .MemtoReg(m2r[0]), .RegWrite(reg_wr[0]),
    .ALUSrcA(src_a[0]), .ALUSrcB(src_b[0]), .ALUControl(alu[0]),
    .PCSrc(pc_src[0]), .PCEn(pc_en[0]), .IllegalOp(illegal[0])
  );

  mips_multicycle_control #(.MEM_WAIT(3)) dut3 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(iord[1]), .MemWrite(mem_wr[1]), .IRWrite(ir_wr[1]),
    .RegDst(reg_dst[1]), .MemtoReg(m2r[1]), .RegWrite(reg_wr[1]),
    .ALUSrcA(src_a[1]), .ALUSrcB(src_b[1]), .ALUControl(alu[1]),
    .PCSrc(pc_src[1]), .PCEn(pc_en[1]), .IllegalOp(illegal[1])
  );

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      act[k].iord       = iord[k];
      act[k].mem_write  = mem_wr[k];
      act[k].ir_write   = ir_wr[k];
      act[k].reg_dst    = reg_dst[k];
      act[k].mem_to_reg = m2r[k];
      act[k].reg_write  = reg_wr[k];
      act[k].src_a      = src_a[k];
      act[k].src_b      = src_b[k];
      act[k].alu        = alu[k];
      act[k].pc_src     = pc_src[k];
      act[k].pc_en      = pc_en[k];
      act[k].illegal    = illegal[k];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t base();
    out_t e;
    e = '0;
    e.alu = 3'b010;
    return e;
  endfunction

  task automatic push(input out_t e, input string nm);
    sb_t s;
    s.e  = e;
    s.nm = nm;
    q.push_back(s);
  endtask

  task automatic push_fetch(input int w, input string nm);
    out_t e;
    for (int i = 0; i <= w; i++) begin
      e = base();
      e.src_b    = 2'b01;
      e.ir_write = (i == w);
      e.pc_en    = (i == w);
      push(e, {nm, ".fetch"});
    end
  endtask

  task automatic push_decode(input logic [5:0] op, input string nm);
    out_t e;
    e = base();
    e.src_b   = 2'b11;
    e.illegal = !(op inside {6'b000000, 6'b100011, 6'b101011,
                             6'b000100, 6'b001000, 6'b000010});
    push(e, {nm, ".decode"});
  endtask

  task automatic push_body(input vec_t v, input int w);
    out_t e;
    case (v.op)
      6'b100011, 6'b101011: begin
        e = base();
        e.src_a = 1'b1;
        e.src_b = 2'b10;
        push(e, {v.name, ".memadr"});
        for (int i = 0; i <= w; i++) begin
          e = base();
          e.iord = 1'b1;
          if (v.op == 6'b101011) e.mem_write = (i == w);
          push(e, {v.name, ".mem"});
        end
        if (v.op == 6'b100011) begin
          e = base();
          e.mem_to_reg = 1'b1;
          e.reg_write  = 1'b1;
          push(e, {v.name, ".memwb"});
        end
      end
      6'b000000: begin
        e = base();
        e.src_a = 1'b1;
        e.alu   = v.alu;
        push(e, {v.name, ".execute"});
        e = base();
        e.reg_dst   = 1'b1;
        e.reg_write = 1'b1;
        push(e, {v.name, ".aluwb"});
      end
      6'b000100: begin
        e = base();
        e.src_a  = 1'b1;
        e.alu    = 3'b110;
        e.pc_src = 2'b01;
        e.pc_en  = v.zero;
        push(e, {v.name, ".branch"});
      end
      6'b001000: begin
        e = base();
        e.src_a = 1'b1;
        e.src_b = 2'b10;
        push(e, {v.name, ".addiex"});
        e = base();
        e.reg_write = 1'b1;
        push(e, {v.name, ".addiwb"});
      end
      6'b000010: begin
        e = base();
        e.pc_src = 2'b10;
        e.pc_en  = 1'b1;
        push(e, {v.name, ".jump"});
      end
      default: ;
    endcase
  endtask

  task automatic drain(input bit w3);
    sb_t  s;
    out_t a;
    while (q.size() > 0) begin
      @(negedge clk);
      s = q.pop_front();
      a = w3 ? act[1] : act[0];
      n_cmp++;
      if (a !== s.e) begin
        n_bad++;
        $display("FAIL %s (mw%0d): got %b want %b",
                 s.nm, w3 ? 3 : 0, a, s.e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input bit w3);
    out_t e;
    reset = 1'b1;
    e = base();
    e.src_b = 2'b01;
    push(e, "reset");
    push(e, "reset");
    drain(w3);
    reset = 1'b0;
  endtask

  task automatic run(input vec_t v, input int w, input bit w3);
    Op    = v.op;
    Funct = v.funct;
    Zero  = v.zero;
    push_fetch(w, v.name);
    push_decode(v.op, v.name);
    push_body(v, w);
    drain(w3);
  endtask

  initial begin
    tv[0]  = '{"lw",     6'b100011, 6'b000000, 1'b0, 3'b010};
    tv[1]  = '{"sw",     6'b101011, 6'b000000, 1'b1, 3'b010};
    tv[2]  = '{"add",    6'b000000, 6'b100000, 1'b1, 3'b010};
    tv[3]  = '{"sub",    6'b000000, 6'b100010, 1'b0, 3'b110};
    tv[4]  = '{"and",    6'b000000, 6'b100100, 1'b0, 3'b000};
    tv[5]  = '{"or",     6'b000000, 6'b100101, 1'b0, 3'b001};
    tv[6]  = '{"slt",    6'b000000, 6'b101010, 1'b0, 3'b111};
    tv[7]  = '{"rt_unk", 6'b000000, 6'b111111, 1'b0, 3'b010};
    tv[8]  = '{"beq_t",  6'b000100, 6'b000000, 1'b1, 3'b110};
    tv[9]  = '{"beq_nt", 6'b000100, 6'b000000, 1'b0, 3'b110};
    tv[10] = '{"addi",   6'b001000, 6'b100010, 1'b1, 3'b010};
    tv[11] = '{"j",      6'b000010, 6'b000000, 1'b1, 3'b010};
    tv[12] = '{"illeg",  6'b111111, 6'b000000, 1'b1, 3'b010};
    tv[13] = '{"lw2",    6'b100011, 6'b000000, 1'b1, 3'b010};

    reset = 1'b1;
    Op    = 6'b000000;
    Funct = 6'b000000;
    Zero  = 1'b0;

    do_reset(1'b0);

    // lw abandoned in MEMADR by a two-cycle reset
    Op = 6'b100011;
    push_fetch(0, "abort");
    push_decode(6'b100011, "abort");
    drain(1'b0);
    do_reset(1'b0);

    for (int i = 0; i < 14; i++) run(tv[i], 0, 1'b0);

    // Wait-state instance: stretched fetch and memory states
    do_reset(1'b1);
    run(tv[1], 3, 1'b1);
    run(tv[0], 3, 1'b1);
    run(tv[12], 3, 1'b1);
    run(tv[8], 3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
